pwm_timer_mc: RTL
=================

// Module: pwm_timer_mc
// PURPOSE
//  Multi-channel PWM timer: one shared period counter drives NCH compare channels.
//  Adds edge-aligned or centre-aligned (up/down) counting, per-channel output polarity and
//  double-buffered (shadow) top/compare/mode/polarity registers that take effect only at a
//  period boundary. Sits behind the peripheral register block; pwm[] goes to pads/motor logic.
// PARAMETERS
//  CNT_W  27  counter, top and compare width in bits
//  NCH    4   number of PWM channels (1..16)
// PORTS
//  CLK           in   1          clock, all state on rising edge
//  RST           in   1          reset, asynchronous, active-high
//  en            in   1          counter enable (live, not shadowed)
//  load          in   1          1-cycle strobe: capture top_in/cmp_in/center_in/pol_in to shadow
//  center_in     in   1          mode to load: 0 edge-aligned, 1 centre-aligned
//  top_in        in   CNT_W      period top value to load
//  cmp_in        in   NCH*CNT_W  compare values to load, channel i = bits [i*CNT_W +: CNT_W]
//  pol_in        in   NCH        polarity to load, 1 = inverted output
//  pwm           out  NCH        PWM outputs
//  period_pulse  out  1          1-cycle pulse at the start of each new period
//  cnt           out  CNT_W      current counter value
// BEHAVIOUR
//  Reset (async): cnt=0, dir=up, active+shadow regs=0, pending=0, period_pulse=0, pwm=0.
//  Shadow: load=1 captures all *_in into shadow, sets pending. Repeated loads overwrite shadow.
//  Boundary event B (en=1 only):
//   - edge mode: cnt==top_act. Next cnt=0. Period = top_act+1 cycles.
//   - centre mode: dir=down and cnt==1, or cnt==top_act==0. Count 0..top,top-1..1 then 0;
//     dir flips to down at cnt==top_act, to up at cnt==0. Period = 2*top_act cycles (1 if top=0).
//  Transfer: on B, if pending or load: active <= (load ? *_in : shadow); pending cleared.
//   load in same cycle as B -> inputs go straight to active (bypass), shadow also updated.
//   If the transfer changes mode, next cnt=0, dir=up regardless of old direction.
//  en=0: cnt<=0, dir<=up each cycle; pending/load transfer to active on the next edge (no wait).
//   pwm[i] = pol_act[i] (inactive level); period_pulse=0.
//  en 0->1: first enabled cycle shows cnt=0 (no pulse); counting advances from next edge.
//  period_pulse: registered; high exactly in the cycle cnt==0 after a B event.
//  Compare (en=1): raw[i] = (cnt < cmp_act[i]); pwm[i] = raw[i] ^ pol_act[i]. Combinational from
//   registers only (cnt, cmp_act, pol_act) - no input feeds pwm directly; glitch-free.
//  Edge cases: cmp=0 -> raw always 0; cmp>top_act -> raw always 1 (100% duty);
//   top_act=0 -> cnt held at 0, period_pulse every cycle; cnt never exceeds top_act except when a
//   smaller top was just made active: if cnt>top_act (only possible via bypass), treat as B.
//  Arithmetic: unsigned, CNT_W-bit; no wrap past 2^CNT_W-1 since top_act <= 2^CNT_W-1.
//  Reset mid-period: immediate return to reset state; pending load lost.
// TESTING
//  1 Reset: RST pulse mid-count (cnt=5) -> cnt, pwm, period_pulse = 0 without a clock edge.
//  2 Edge: top=9, cmp0=3, cmp1=10, pol=0, en=1 -> pwm0 high 3/10 cycles (cnt 0..2), pwm1 always 1,
//    period_pulse every 10 cycles at cnt==0.
//  3 Centre: top=4, cmp0=2 -> cnt 0,1,2,3,4,3,2,1 repeat; pwm0 high at cnt 0,1,1 (3/8);
//    period_pulse every 8 cycles; pol0=1 -> exact complement.
//  4 Shadow: edge top=9 cmp0=3, load cmp0=7 at cnt==4 -> duty stays 3 to end of period,
//    7/10 from the next cnt==0; load coinciding with cnt==9 -> 7 applies on that same wrap.
//  5 Limits: cmp0=0 -> pwm0 constant 0; top=0 -> cnt stays 0, period_pulse every cycle;
//    mode switch edge->centre via load -> cnt restarts 0, dir up at boundary.
//  6 Disable: en=0 mid-period with pol0=1 -> next edge cnt=0, pwm0=1, no pulse; load while
//    disabled -> active regs updated on next edge.

Source files
------------

// File: rtl/pwm_timer_mc_if.sv
// pwm_timer_mc_if: configuration inputs and PWM outputs of the multi-channel PWM timer
interface pwm_timer_mc_if #(
    parameter int CNT_W = 27,
    parameter int NCH   = 4
);
    logic                 en;
    logic                 load;
    logic                 center_in;
    logic [CNT_W-1:0]     top_in;
    logic [NCH*CNT_W-1:0] cmp_in;
    logic [NCH-1:0]       pol_in;
    logic [NCH-1:0]       pwm;
    logic                 period_pulse;
    logic [CNT_W-1:0]     cnt;
    modport master (output en, load, center_in, top_in, cmp_in, pol_in, input pwm, period_pulse, cnt);
    modport slave  (input en, load, center_in, top_in, cmp_in, pol_in, output pwm, period_pulse, cnt);
endinterface

// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: shared edge/centre-aligned period counter with NCH double-buffered compare channels
module pwm_timer_mc #(
    parameter int CNT_W = 27,
    parameter int NCH   = 4
) (
    input logic             CLK,
    input logic             RST,
    pwm_timer_mc_if.slave   bus
);
    typedef enum logic {UP, DOWN} dir_t;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    dir_t                 dir, dir_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx, top_act, top_sh;
    logic [NCH*CNT_W-1:0] cmp_act, cmp_sh;
    logic [NCH-1:0]       pol_act, pol_sh;
    logic                 ctr_act, ctr_sh, pend, en_q, pulse, bnd, xfer;

    // next count/direction; a boundary restarts at 0 going up, a top reached in centre mode turns down
    always_comb begin
        bnd = ctr_act ? (cnt_q > top_act || (cnt_q == top_act && top_act <= ONE) || (dir == DOWN && cnt_q == ONE))
                      : (cnt_q >= top_act);
        xfer = (!bus.en || bnd) && (pend || bus.load);
        cnt_nx = cnt_q + ONE;
        dir_nx = dir;
        if (!bus.en || bnd) begin
            cnt_nx = '0;
            dir_nx = UP;
        end else if (ctr_act && (dir == DOWN || cnt_q == top_act)) begin
            cnt_nx = cnt_q - ONE;
            dir_nx = DOWN;
        end
    end

    // counter, direction, shadow and active register updates
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            dir     <= UP;
            en_q    <= 1'b0;
            pulse   <= 1'b0;
            pend    <= 1'b0;
            top_act <= '0;
            cmp_act <= '0;
            pol_act <= '0;
            ctr_act <= 1'b0;
            top_sh  <= '0;
            cmp_sh  <= '0;
            pol_sh  <= '0;
            ctr_sh  <= 1'b0;
        end else begin
            cnt_q <= cnt_nx;
            dir   <= dir_nx;
            en_q  <= bus.en;
            pulse <= bus.en && bnd;
            if (bus.load) begin
                top_sh <= bus.top_in;
                cmp_sh <= bus.cmp_in;
                pol_sh <= bus.pol_in;
                ctr_sh <= bus.center_in;
            end
            if (xfer) begin
                top_act <= bus.load ? bus.top_in : top_sh;
                cmp_act <= bus.load ? bus.cmp_in : cmp_sh;
                pol_act <= bus.load ? bus.pol_in : pol_sh;
                ctr_act <= bus.load ? bus.center_in : ctr_sh;
                pend    <= 1'b0;
            end else if (bus.load) begin
                pend <= 1'b1;
            end
        end
    end

    // outputs depend on registers only; a disabled timer parks every channel at its inactive level
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign bus.pwm[i] = en_q ? ((cnt_q < cmp_act[i*CNT_W +: CNT_W]) ^ pol_act[i]) : pol_act[i];
    end
    assign bus.cnt          = cnt_q;
    assign bus.period_pulse = pulse;
endmodule
